// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger transmit path and its input-side sibling.
package trigger_pkg;

    localparam int FRAME_LEN = 10;
    localparam int POS_W     = 4;
    localparam int POS_MAX   = 9;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT,
        PULSE,
        HOLD
    } trg_state_t;

endpackage

// File: rtl/frame_phase_cnt.sv
// Sub-frame phase counter: cleared by the frame marker, counts clk400 cycles
// after it and parks at all-ones when frame markers stop arriving.
module frame_phase_cnt
    import trigger_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame,
    output logic [POS_W-1:0] o_phase
);

    localparam logic [POS_W-1:0] PHASE_SAT = '1;

    logic [POS_W-1:0] r_phase;

    // Phase register: 0 in the cycle after a frame marker, then +1 per cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (i_frame) begin
            r_phase <= '0;
        end else if (r_phase != PHASE_SAT) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/trigger_out_async.sv
// Trigger output sequencer: accepts a request tagged with a fine position on a
// frame cycle, launches a WIDTH-cycle pulse at that position in the following
// frame, then holds off for HOLDOFF frames before accepting again.
// Optional feature macro: TRG_OUT_DROPCNT_EN builds the saturating drop counter;
// without it drop_cnt is tied to zero.
//
// state | meaning
// IDLE  | ready to accept a request on the next frame cycle
// ARMED | request latched, waiting for the launch frame
// WAIT  | launch frame seen, counting phase up to the fine position
// PULSE | driving trg_out for WIDTH cycles
// HOLD  | counting HOLDOFF frames before returning to IDLE
module trigger_out_async
    import trigger_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int HOLDOFF = 3
) (
    input  logic             clk400,
    input  logic             reset_n,
    input  logic             frame,
    input  logic             trg_req,
    input  logic [POS_W-1:0] trg_pos,
    output logic             trg_out,
    output logic             busy,
    output logic             drop,
    output logic [7:0]       drop_cnt
);

    localparam logic [POS_W-1:0] POS_LIMIT  = POS_W'(POS_MAX);
    localparam logic [3:0]       WIDTH_LAST = 4'(WIDTH - 1);
    localparam logic [2:0]       HOLD_LOAD  = 3'(HOLDOFF);

    trg_state_t       r_state;
    trg_state_t       w_state_nxt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_phase;
    logic [3:0]       r_wcnt;
    logic [2:0]       r_hcnt;
    logic             r_trg_out;
    logic             r_drop;
    logic             w_req;
    logic             w_accept;
    logic             w_reject;

    frame_phase_cnt u_phase (
        .i_clk   (clk400),
        .i_rst_n (reset_n),
        .i_frame (frame),
        .o_phase (w_phase)
    );

    assign w_req    = frame & trg_req;
    assign w_accept = w_req && (r_state == IDLE) && (trg_pos <= POS_LIMIT);
    assign w_reject = w_req && !w_accept;

    // Next-state decode; a frame in WAIT restarts the phase so it wins over the match.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ARMED;
            ARMED:   if (frame) w_state_nxt = (r_pos == '0) ? PULSE : WAIT;
            WAIT:    if (!frame && (w_phase == r_pos - 1'b1)) w_state_nxt = PULSE;
            PULSE:   if (r_wcnt == '0) w_state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
            HOLD:    if (frame && (r_hcnt == 3'd1)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, latched position and registered pin drives.
    always_ff @(posedge clk400) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pos     <= '0;
            r_trg_out <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_trg_out <= (w_state_nxt == PULSE);
            r_drop    <= w_reject;
            if (w_accept) begin
                r_pos <= trg_pos;
            end
        end
    end

    // Width and holdoff down-counters, preloaded while their state is inactive.
    always_ff @(posedge clk400) begin
        if (!reset_n) begin
            r_wcnt <= '0;
            r_hcnt <= '0;
        end else begin
            if (r_state != PULSE) begin
                r_wcnt <= WIDTH_LAST;
            end else if (r_wcnt != '0) begin
                r_wcnt <= r_wcnt - 1'b1;
            end
            if (r_state != HOLD) begin
                r_hcnt <= HOLD_LOAD;
            end else if (frame && (r_hcnt != '0)) begin
                r_hcnt <= r_hcnt - 1'b1;
            end
        end
    end

    assign trg_out = r_trg_out;
    assign drop    = r_drop;
    assign busy    = (r_state != IDLE);

`ifdef TRG_OUT_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of rejected requests, updated alongside the drop pulse.
    always_ff @(posedge clk400) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (w_reject && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_trigger_out_async.sv
// Scoreboard bench for trigger_out_async: frames every 10 cycles, directed
// scenarios followed by random requests; expectations come from a cycle
// arithmetic model of the request/pulse/holdoff rules.
module tb_trigger_out_async;
    import trigger_pkg::*;

    localparam int WIDTH   = 4;
    localparam int HOLDOFF = 3;
    localparam int PERIOD  = 10;
    localparam int NCYC    = 8192;

    logic       clk400  = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame   = 1'b0;
    logic       trg_req = 1'b0;
    logic [3:0] trg_pos = 4'd0;
    logic       trg_out;
    logic       busy;
    logic       drop;
    logic [7:0] drop_cnt;

    trigger_out_async #(.WIDTH(WIDTH), .HOLDOFF(HOLDOFF)) dut (
        .clk400   (clk400),
        .reset_n  (reset_n),
        .frame    (frame),
        .trg_req  (trg_req),
        .trg_pos  (trg_pos),
        .trg_out  (trg_out),
        .busy     (busy),
        .drop     (drop),
        .drop_cnt (drop_cnt)
    );

    always #5 clk400 = ~clk400;

    int cyc = 0;
    always @(posedge clk400) cyc <= cyc + 1;

    int  n_vec = 0;
    int  n_bad = 0;
    int  m_free = 0;
    int  exp_drops = 0;
    bit  exp_busy [NCYC];
    int  q_drop [$];
    int  q_ps [$];
    bit  mon_en = 1'b0;
    bit  noise_en = 1'b1;
    bit  hold_req = 1'b0;
    int  pre_chk = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int first_frame_ge(input int c);
        return ((c + PERIOD - 1) / PERIOD) * PERIOD;
    endfunction

    function automatic int exp_dropcnt();
`ifdef TRG_OUT_DROPCNT_EN
        return exp_drops;
`else
        return 0;
`endif
    endfunction

    // Reference model: decide accept/drop for a request on frame cycle t.
    task automatic model_frame(input int t, input bit req, input int pos);
        int k, f, e;
        if (!req) return;
        if (t >= m_free && pos <= POS_MAX) begin
            k = t + PERIOD;
            f = k + pos + WIDTH + 1;
            q_ps.push_back(k + pos + 1);
            if (HOLDOFF == 0) begin
                e = f - 1;
                m_free = f;
            end else begin
                e = first_frame_ge(f) + PERIOD * (HOLDOFF - 1);
                m_free = e + 1;
            end
            for (int i = t + 1; i <= e && i < NCYC; i++) exp_busy[i] = 1'b1;
        end else begin
            q_drop.push_back(t + 1);
            if (exp_drops < 255) exp_drops++;
        end
    endtask

    // Drive one cycle; outputs visible at this negedge belong to cycle c.
    task automatic tick(input bit fr_req, input logic [3:0] fr_pos, input bit rst, output int c);
        @(negedge clk400);
        c = cyc + 1;
        if (pre_chk == 1) begin
            check("trg_out_before_reset", int'(trg_out), 1);
        end else if (pre_chk == 2) begin
            check("trg_out_after_reset", int'(trg_out), 0);
            check("busy_after_reset", int'(busy), 0);
        end
        pre_chk = 0;
        reset_n = !rst;
        frame   = (c % PERIOD == 0);
        if (frame) begin
            trg_req = fr_req;
            trg_pos = fr_pos;
        end else if (hold_req) begin
            trg_req = 1'b1;
            trg_pos = fr_pos;
        end else if (noise_en) begin
            trg_req = ($urandom % 2) != 0;
            trg_pos = 4'($urandom % 16);
        end else begin
            trg_req = 1'b0;
            trg_pos = 4'd0;
        end
        if (frame && !rst) model_frame(c, fr_req, int'(fr_pos));
    endtask

    task automatic goto_frame(input bit req, input logic [3:0] pos, output int c);
        do tick(req, pos, 1'b0, c); while (c % PERIOD != 0);
    endtask

    task automatic idle_cycles(input int n);
        int c;
        repeat (n) tick(1'b0, 4'd0, 1'b0, c);
    endtask

    task automatic chk_dropcnt(input string name);
        int c;
        do tick(1'b0, 4'd0, 1'b0, c); while (c % PERIOD != 5);
        check(name, int'(drop_cnt), exp_dropcnt());
    endtask

    // Monitor: pops expectations whenever the DUT shows a drop or completes a pulse.
    bit in_pulse = 1'b0;
    int p_start  = 0;
    int mon_oc   = 0;
    int mon_exp  = 0;
    always @(negedge clk400) begin
        mon_oc = cyc + 1;
        if (!mon_en) begin
            in_pulse = 1'b0;
        end else begin
            check("busy", int'(busy), int'(exp_busy[mon_oc]));
            if (trg_out && !in_pulse) begin
                in_pulse = 1'b1;
                p_start  = mon_oc;
            end else if (!trg_out && in_pulse) begin
                in_pulse = 1'b0;
                if (q_ps.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", p_start);
                end else begin
                    mon_exp = q_ps.pop_front();
                    check("pulse_start", p_start, mon_exp);
                    check("pulse_width", mon_oc - p_start, WIDTH);
                end
            end
            if (drop) begin
                if (q_drop.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_drop: got drop at cycle %0d, expected none", mon_oc);
                end else begin
                    mon_exp = q_drop.pop_front();
                    check("drop_cycle", mon_oc, mon_exp);
                end
            end
        end
    end

    initial begin
        int c, acc;

        // Reset state.
        repeat (3) tick(1'b0, 4'd0, 1'b1, c);
        check("rst_trg_out", int'(trg_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        idle_cycles(2);
        mon_en = 1'b1;

        // pos=0 launch, then pos=9 straddling the next frame.
        goto_frame(1'b1, 4'd0, c);
        idle_cycles(80);
        goto_frame(1'b1, 4'd9, c);
        goto_frame(1'b0, 4'd0, c);
        // Requests during PULSE and on the first HOLD frame are dropped.
        goto_frame(1'b1, 4'd5, c);
        goto_frame(1'b1, 4'd5, c);
        idle_cycles(60);
        chk_dropcnt("drop_cnt_after_two");

        // Out-of-range position is dropped from IDLE.
        goto_frame(1'b1, 4'd12, c);
        idle_cycles(30);
        chk_dropcnt("drop_cnt_bad_pos");
        check("pending_pulses_a", q_ps.size(), 0);
        check("pending_drops_a", q_drop.size(), 0);

        // Reset in the middle of a pulse.
        mon_en = 1'b0;
        idle_cycles(2);
        goto_frame(1'b1, 4'd0, acc);
        do tick(1'b0, 4'd0, 1'b0, c); while (c < acc + PERIOD + 1);
        pre_chk = 1;
        tick(1'b0, 4'd0, 1'b1, c);
        q_ps.delete();
        q_drop.delete();
        m_free = 0;
        exp_drops = 0;
        for (int i = c + 1; i < NCYC; i++) exp_busy[i] = 1'b0;
        pre_chk = 2;
        tick(1'b0, 4'd0, 1'b1, c);
        idle_cycles(3);
        mon_en = 1'b1;
        chk_dropcnt("drop_cnt_cleared");
        goto_frame(1'b1, 4'd3, c);
        idle_cycles(70);

        // Continuous request: launches every 1 + 1 + HOLDOFF frames, drops in between.
        hold_req = 1'b1;
        for (int i = 0; i < 25; i++) goto_frame(1'b1, 4'd2, c);
        hold_req = 1'b0;
        idle_cycles(80);
        chk_dropcnt("drop_cnt_continuous");

        // Random traffic.
        for (int i = 0; i < 200; i++)
            goto_frame(($urandom % 2) != 0, 4'($urandom_range(0, 11)), c);
        idle_cycles(90);
        chk_dropcnt("drop_cnt_random");
        check("pending_pulses_end", q_ps.size(), 0);
        check("pending_drops_end", q_drop.size(), 0);
        check("pulse_open_end", int'(in_pulse), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
